// File: rtl/fpmod_iter_pkg.sv
// Shared types and constants for the fixed-point modulo unit.
package fpmod_iter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic MODE_TRUNC = 1'b0;
    localparam logic MODE_FLOOR = 1'b1;

endpackage

// File: rtl/fpmod_divstep.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module fpmod_divstep #(
    parameter int unsigned W = 31
) (
    input  logic [W-1:0] r_in,
    input  logic         a_bit,
    input  logic [W-1:0] b,
    output logic [W-1:0] r_out,
    output logic         q_bit
);

    logic [W:0] trial;
    logic [W:0] diff;

    // r_in < b always holds, so both the restored and subtracted results fit in W bits
    always_comb begin
        trial = {r_in, a_bit};
        diff  = trial - {1'b0, b};
        q_bit = (trial >= {1'b0, b});
        r_out = q_bit ? diff[W-1:0] : trial[W-1:0];
    end

endmodule

// File: rtl/fpmod_iter.sv
// Sign-magnitude fixed-point remainder/quotient using a bit-serial restoring divider.
module fpmod_iter
    import fpmod_iter_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned Q = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] in_1,
    input  logic [N-1:0] in_2,
    output logic [N-1:0] rem,
    output logic [N-1:0] quo,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic         quo_ovf
);

    localparam int unsigned M  = N - 1;
    localparam int unsigned I  = N - 1 - Q;
    localparam int unsigned CW = $clog2(M);

    state_e        state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [M-1:0]  b_q, b_d;
    logic [M-1:0]  r_q, r_d;
    logic [M-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          mode_q, mode_d;
    logic          dz_q, dz_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          div_zero_q, div_zero_d;
    logic          quo_ovf_q, quo_ovf_d;

    logic [M-1:0]  step_r;
    logic          step_q;

    logic          floor_adj;
    logic [M-1:0]  rem_mag;
    logic          rem_sign;
    logic [N-1:0]  quo_sum;
    logic          quo_big;
    logic [I-1:0]  quo_mag;
    logic          quo_sign;

    fpmod_divstep #(.W(M)) u_step (
        .r_in  (r_q),
        .a_bit (a_q[M-1]),
        .b     (b_q),
        .r_out (step_r),
        .q_bit (step_q)
    );

    // Sign fix-up, floored adjustment and quotient saturation from the finished divide
    always_comb begin
        floor_adj = (mode_q == MODE_FLOOR) && (s1_q != s2_q) && (r_q != '0);
        rem_mag   = floor_adj ? (b_q - r_q) : r_q;
        rem_sign  = floor_adj ? s2_q : s1_q;
        quo_sum   = {1'b0, q_q} + N'(floor_adj);
        quo_big   = |quo_sum[N-1:I];
        quo_mag   = quo_big ? {I{1'b1}} : quo_sum[I-1:0];
        quo_sign  = floor_adj ? 1'b1 : (s1_q ^ s2_q);
    end

    // Next-state and register updates for the control FSM
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        mode_d     = mode_q;
        dz_d       = dz_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        busy_d     = busy_q;
        done_d     = done_q;
        div_zero_d = div_zero_q;
        quo_ovf_d  = quo_ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = in_1[M-1:0];
                    b_d     = in_2[M-1:0];
                    s1_d    = in_1[N-1];
                    s2_d    = in_2[N-1];
                    mode_d  = mode;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (b_q == '0) begin
                    dz_d    = 1'b1;
                    state_d = ST_FIX;
                end else begin
                    dz_d    = 1'b0;
                    r_d     = '0;
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                r_d   = step_r;
                q_d   = {q_q[M-2:0], step_q};
                a_d   = {a_q[M-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(M - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                done_d  = 1'b1;
                state_d = ST_DONE;
                if (dz_q) begin
                    rem_d      = '0;
                    quo_d      = '0;
                    div_zero_d = 1'b1;
                    quo_ovf_d  = 1'b0;
                end else begin
                    rem_d      = {rem_sign & (|rem_mag), rem_mag};
                    quo_d      = {quo_sign & (|quo_mag), quo_mag, {Q{1'b0}}};
                    div_zero_d = 1'b0;
                    quo_ovf_d  = quo_big;
                end
            end
            ST_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            mode_q     <= 1'b0;
            dz_q       <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            quo_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            mode_q     <= mode_d;
            dz_q       <= dz_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            quo_ovf_q  <= quo_ovf_d;
        end
    end

    assign rem      = rem_q;
    assign quo      = quo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign quo_ovf  = quo_ovf_q;

endmodule

// File: tb/tb_fpmod_iter.sv
// Directed scoreboard bench for fpmod_iter (N=32, Q=16).
module tb_fpmod_iter;

    localparam int unsigned N = 32;
    localparam int unsigned Q = 16;

    typedef struct packed {
        logic [N-1:0] rem;
        logic [N-1:0] quo;
        logic         dz;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [N-1:0] in_1;
    logic [N-1:0] in_2;
    logic [N-1:0] rem;
    logic [N-1:0] quo;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic         quo_ovf;

    int   total;
    int   bad;
    int   done_cnt;
    exp_t sb[$];

    fpmod_iter #(.N(N), .Q(Q)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .in_1     (in_1),
        .in_2     (in_2),
        .rem      (rem),
        .quo      (quo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .quo_ovf  (quo_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result and compares it
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                e = sb.pop_front();
                chk("rem", rem, e.rem);
                chk("quo", quo, e.quo);
                chk("div_zero", N'(div_zero), N'(e.dz));
                chk("quo_ovf", N'(quo_ovf), N'(e.ovf));
            end
        end
    end

    // Issue one op, push its expectation, and check done arrives lat edges after the accept edge
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                          input logic [N-1:0] er, input logic [N-1:0] eq,
                          input logic edz, input logic eovf, input int lat);
        int k;
        exp_t e;
        e.rem = er; e.quo = eq; e.dz = edz; e.ovf = eovf;
        sb.push_back(e);
        @(negedge clk);
        in_1 = a; in_2 = b; mode = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; in_1 = '0; in_2 = '0; mode = 1'b0;
        chk("busy_after_accept", N'(busy), N'(1));
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency", N'(k), N'(lat));
        @(posedge clk);
        #1;
        chk("done_one_cycle", N'(done), N'(0));
        chk("busy_cleared", N'(busy), N'(0));
    endtask

    initial begin
        int dc0;
        total = 0; bad = 0; done_cnt = 0;
        rst = 1'b0; start = 1'b0; mode = 1'b0; in_1 = '0; in_2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_rem", rem, '0);
        chk("reset_quo", quo, '0);
        chk("reset_flags", N'({busy, done, div_zero, quo_ovf}), '0);

        // 5.5 mod 2 truncated: q=2, r=1.5
        run_op(32'h0005_8000, 32'h0002_0000, 1'b0, 32'h0001_8000, 32'h0002_0000, 1'b0, 1'b0, 33);
        // -5.5 mod 2 truncated and floored
        run_op(32'h8005_8000, 32'h0002_0000, 1'b0, 32'h8001_8000, 32'h8002_0000, 1'b0, 1'b0, 33);
        run_op(32'h8005_8000, 32'h0002_0000, 1'b1, 32'h0000_8000, 32'h8003_0000, 1'b0, 1'b0, 33);
        // -6 mod 2 floored: exact multiple, no negative zero remainder
        run_op(32'h8006_0000, 32'h0002_0000, 1'b1, 32'h0000_0000, 32'h8003_0000, 1'b0, 1'b0, 33);
        // 5.5 mod -2 floored: rem = -(2-1.5), quo = -3
        run_op(32'h0005_8000, 32'h8002_0000, 1'b1, 32'h8000_8000, 32'h8003_0000, 1'b0, 1'b0, 33);
        // divisor negative zero: LOAD goes straight to FIX, done set by the second edge after accept
        run_op(32'h0005_8000, 32'h8000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 2);
        // next normal op clears div_zero; -0.5 / 2 truncated gives quo magnitude 0 (sign dropped)
        run_op(32'h8000_8000, 32'h0002_0000, 1'b0, 32'h8000_8000, 32'h0000_0000, 1'b0, 1'b0, 33);
        // quotient overflow saturates to integer all-ones
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'h7FFF_0000, 1'b0, 1'b1, 33);

        // start pulsed while busy is ignored: one expected result, one done pulse
        dc0 = done_cnt;
        sb.push_back('{rem: 32'h0000_4000, quo: 32'h0003_0000, dz: 1'b0, ovf: 1'b0});
        @(negedge clk);
        in_1 = 32'h0003_4000; in_2 = 32'h0001_0000; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_1 = '0; in_2 = '0;
        repeat (4) @(negedge clk);
        in_1 = 32'h0009_0000; in_2 = 32'h0002_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_1 = '0; in_2 = '0;
        repeat (80) @(negedge clk);
        chk("single_done_pulse", N'(done_cnt - dc0), N'(1));
        chk("scoreboard_drained", N'(sb.size()), N'(0));

        // reset in the middle of an op: everything clears and no done follows
        dc0 = done_cnt;
        @(negedge clk);
        in_1 = 32'h0005_8000; in_2 = 32'h0002_0000; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_rem", rem, '0);
        chk("midreset_quo", quo, '0);
        chk("midreset_flags", N'({busy, done, div_zero, quo_ovf}), '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("midreset_no_done", N'(done_cnt - dc0), N'(0));

        // fresh op after reset release completes normally
        run_op(32'h0005_8000, 32'h0002_0000, 1'b0, 32'h0001_8000, 32'h0002_0000, 1'b0, 1'b0, 33);
        repeat (3) @(negedge clk);
        chk("final_scoreboard_empty", N'(sb.size()), N'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
